ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte, e.g. 0xF4 (enable data reporting) or 0xFF (reset), from the FPGA to the mouse.
- Works alongside the existing PS/2 mouse receive path on the same ps2_clk/ps2_data pair.
- Drives both lines open-drain through output-enable signals. The top level owns the tristate buffers and must hold the receive path off while busy is high.

Parameters:
- INHIBIT_CYCLES, 12000: clock-low inhibit time before the request-to-send (120 us at 100 MHz).
- TIMEOUT_CYCLES, 2000000: maximum wait for any expected ps2_clk falling edge (20 ms).
- FILTER_LEN, 8: consecutive identical synchronized samples needed before the filtered line level changes.

Ports:
- clk100MHz  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- tx_data  in  8  command byte
- tx_valid  in  1  request to send tx_data
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw ps2_clk line level
- ps2_data_in  in  1  raw ps2_data line level
- ps2_clk_oe  out  1  1 = pull ps2_clk low
- ps2_data_oe  out  1  1 = pull ps2_data low
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on successful, acknowledged transfer
- err  out  1  one-cycle pulse on failure
- err_nack  out  1  valid with err: 1 = device did not ACK, 0 = timeout

Behaviour:
- Reset (asynchronous, applies immediately):
  - ps2_clk_oe=0, ps2_data_oe=0, done=0, err=0, err_nack=0, busy=0, tx_ready=1.
  - State goes to IDLE; counters clear; both filtered line levels are set to 1.
- Input conditioning:
  - Each input passes through a 2-flop synchronizer, then the FILTER_LEN glitch filter.
  - A falling edge (fe) is a filtered ps2_clk transition 1->0, flagged for exactly one cycle.
- Handshake:
  - A byte is accepted on the cycle where tx_valid && tx_ready.
  - On acceptance: latch tx_data; compute parity = ~^tx_data (odd parity); enter INHIBIT on the next cycle.
  - tx_valid is ignored while busy.
- State machine:
  - IDLE: both oe=0.
  - INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for INHIBIT_CYCLES cycles.
  - RTS, first cycle: ps2_data_oe=1 (start bit 0) while ps2_clk_oe is still 1. Next cycle: ps2_clk_oe=0. Clear the timeout counter and bit index.
  - SEND: ps2_data_oe = ~(current bit).
    - fe #1..#8: present data bits 0..7, LSB first.
    - fe #9: present the parity bit.
    - fe #10: release data (stop bit 1).
  - ACK: on fe #11, sample filtered data. 0 = ACK; 1 = NACK, which pulses err with err_nack=1 and returns to IDLE.
  - WAIT_REL: after ACK, wait until filtered clk and data are both 1, then pulse done and return to IDLE.
- Timeout:
  - The counter runs in RTS, SEND, ACK and WAIT_REL, and clears on every fe.
  - When it reaches TIMEOUT_CYCLES: release both lines, pulse err with err_nack=0, return to IDLE.
- Simultaneous events: an fe and a timeout in the same cycle resolves as the fe (the timeout is not reported).
- Data-change timing: data changes in the cycle after an fe is detected, which is well inside the device's clock-low half-period.
- Width rules:
  - Bit index is 4 bits and saturates at 11.
  - Counter width is $clog2(max(INHIBIT_CYCLES, TIMEOUT_CYCLES)+1).
- Interaction with the receive path: the receive path can observe the transmit handshake as garbage. Only done/err determine the outcome of a transfer.

Optional Feature:
- PS2_TX_RETRY_EN defined:
  - On the first NACK or timeout of an accepted byte, silently restart from INHIBIT with the same latched byte.
  - err pulses only if the retry also fails.
  - busy stays high across the retry.
- PS2_TX_RETRY_EN not defined: the first failure pulses err immediately.

Test Plan:
- Send 0xF4 with a device model clocking at ~12.5 kHz:
  - ps2_clk_oe held low ≥12000 cycles; start bit 0.
  - Data bits 0,0,1,0,1,1,1,1; parity 0; stop 1.
  - Model ACKs -> single done pulse; err never asserted; tx_ready returns to 1.
- Send 0xFF -> 8 data bits all 1; parity 1. Send 0x00 -> parity 1. Both receive ACK -> done.
- Model releases data at the ACK clock (NACK) on 0xF4 -> err=1 with err_nack=1, both oe=0 within 1 cycle.
  - With PS2_TX_RETRY_EN: a second full frame is observed; if it is ACKed -> done and no err.
- Model never clocks after RTS -> err pulse with err_nack=0 exactly TIMEOUT_CYCLES after clk release; lines released.
- Inject 3-cycle glitches on ps2_clk_in during SEND -> no extra bits shifted; frame still correct.
- Assert rst at fe #5 -> both oe drop to 0 immediately, tx_ready=1. A subsequent 0xF4 completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the device over the shared
// ps2_clk/ps2_data pair. Lines are driven open-drain through ps2_clk_oe/ps2_data_oe.
// Optional build macro PS2_TX_RETRY_EN: the first NACK or timeout of a byte silently
// restarts the frame from INHIBIT; err only pulses if that retry also fails.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 12000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned FILTER_LEN     = 8
) (
  input  logic       clk100MHz,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       err_nack
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned FiltW  = $clog2(FILTER_LEN + 1);
  localparam logic [CntW-1:0]  InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0]  TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [FiltW-1:0] FiltLast    = FiltW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {StIdle, StInhibit, StRts, StSend, StAck, StWaitRel} state_e;

  // Index 0 = ps2_clk, index 1 = ps2_data.
  logic [1:0]       sync1_q, sync2_q, filt_q;
  logic [FiltW-1:0] fcnt_q [2];
  logic             clk_prev_q;
  logic             fe;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic [7:0]      byte_q, byte_d;
  logic            par_q, par_d;
  logic [1:0]      oe_q;
  logic            done_q, done_d, err_q, err_d, nack_q, nack_d;
  logic            fail, fail_nack;
`ifdef PS2_TX_RETRY_EN
  logic            retry_q, retry_d;
`endif

  // Frame bit presented while idx fe's have been seen: start, d0..d7, parity, then stop.
  function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b,
                                     input logic p);
    logic [9:0] frame;
    frame = {p, b, 1'b0};
    if (idx < 4'd10) return frame[idx];
    return 1'b1;
  endfunction

  // {clk_oe, data_oe} for a given state; registered so the lines never glitch.
  function automatic logic [1:0] oe_of(input state_e st, input logic [3:0] idx,
                                       input logic [7:0] b, input logic p);
    case (st)
      StInhibit: return 2'b10;
      StRts:     return 2'b11;
      StSend:    return {1'b0, ~frame_bit(idx, b, p)};
      default:   return 2'b00;
    endcase
  endfunction

  // Two-flop synchronizers followed by a run-length glitch filter on each line.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      filt_q     <= 2'b11;
      clk_prev_q <= 1'b1;
      fcnt_q[0]  <= '0;
      fcnt_q[1]  <= '0;
    end else begin
      sync1_q    <= {ps2_data_in, ps2_clk_in};
      sync2_q    <= sync1_q;
      clk_prev_q <= filt_q[0];
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == filt_q[i]) begin
          fcnt_q[i] <= '0;
        end else if (fcnt_q[i] == FiltLast) begin
          filt_q[i] <= sync2_q[i];
          fcnt_q[i] <= '0;
        end else begin
          fcnt_q[i] <= fcnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign fe = clk_prev_q & ~filt_q[0];

  // Next-state logic: one shared counter serves the inhibit delay and the edge timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    par_d     = par_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    nack_d    = 1'b0;
    fail      = 1'b0;
    fail_nack = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          byte_d  = tx_data;
          par_d   = ~^tx_data;
          cnt_d   = '0;
          state_d = StInhibit;
`ifdef PS2_TX_RETRY_EN
          retry_d = 1'b0;
`endif
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          cnt_d   = '0;
          state_d = StRts;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRts: begin
        cnt_d   = '0;
        idx_d   = '0;
        state_d = StSend;
      end
      StSend, StAck, StWaitRel: begin
        if (state_q == StWaitRel && filt_q == 2'b11) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (fe) begin
          // An edge always wins over a coincident timeout.
          cnt_d = '0;
          if (idx_q != 4'd11) idx_d = idx_q + 1'b1;
          if (state_q == StSend && idx_q == 4'd9) begin
            state_d = StAck;
          end else if (state_q == StAck) begin
            if (filt_q[1]) begin
              fail      = 1'b1;
              fail_nack = 1'b1;
            end else begin
              state_d = StWaitRel;
            end
          end
        end else if (cnt_q == TimeoutLast) begin
          fail = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (fail) begin
      cnt_d   = '0;
      state_d = StIdle;
`ifdef PS2_TX_RETRY_EN
      if (!retry_q) begin
        retry_d = 1'b1;
        state_d = StInhibit;
      end else begin
        err_d  = 1'b1;
        nack_d = fail_nack;
      end
`else
      err_d  = 1'b1;
      nack_d = fail_nack;
`endif
    end
  end

  // State, datapath and registered line/status outputs.
  always_ff @(posedge clk100MHz or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
      oe_q    <= 2'b00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      nack_q  <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      par_q   <= par_d;
      oe_q    <= oe_of(state_d, idx_d, byte_d, par_d);
      done_q  <= done_d;
      err_q   <= err_d;
      nack_q  <= nack_d;
`ifdef PS2_TX_RETRY_EN
      retry_q <= retry_d;
`endif
    end
  end

  assign ps2_clk_oe  = oe_q[1];
  assign ps2_data_oe = oe_q[0];
  assign tx_ready    = (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign err         = err_q;
  assign err_nack    = nack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host,
// expected frames/outcomes are queued at send time and popped when the device finishes.
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int unsigned Inh  = 200;
  localparam int unsigned Tmo  = 3000;
  localparam int unsigned Flt  = 8;
  localparam int          Half = 40;

  logic       clk100MHz = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err, err_nack;
  logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(Inh),
    .TIMEOUT_CYCLES(Tmo),
    .FILTER_LEN    (Flt)
  ) dut (
    .clk100MHz  (clk100MHz),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_line),
    .ps2_data_in(ps2_data_line),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_nack   (err_nack)
  );

  always #5 clk100MHz = ~clk100MHz;

  int errors = 0;
  int checks = 0;
  logic [10:0] exp_q[$];
  int          exp_res_q[$];  // 0 = done, 1 = NACK error, 2 = timeout error

  int       cyc_cnt = 0;
  int       done_cnt = 0, err_cnt = 0, err_cyc = 0;
  logic     last_nack = 1'b0;
  logic [1:0] err_oe = 2'b00;

  always @(posedge clk100MHz) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk100MHz) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (err === 1'b1) begin
      err_cnt   <= err_cnt + 1;
      last_nack <= err_nack;
      err_oe    <= {ps2_clk_oe, ps2_data_oe};
      err_cyc   <= cyc_cnt;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk100MHz);
  endtask

  task automatic send_byte(input logic [7:0] b, input int res);
    int t = 0;
    while (tx_ready !== 1'b1 && t < 1000) begin cyc(1); t++; end
    tx_data  = b;
    tx_valid = 1'b1;
    cyc(1);
    tx_valid = 1'b0;
    exp_q.push_back({1'b1, ~^b, b, 1'b0});
    exp_res_q.push_back(res);
  endtask

  // Device side of one frame; stop_after > 0 returns with ps2_clk held low at that pulse.
  task automatic dev_frame(input bit ack, input bit glitch, input int stop_after,
                           output logic [10:0] bits, output int inh, output logic start_oe);
    int t = 0;
    bits = '1;
    inh = 0;
    while (ps2_clk_oe !== 1'b1 && t < 2000) begin cyc(1); t++; end
    while (ps2_clk_oe === 1'b1 && inh < 2000) begin cyc(1); inh++; end
    start_oe = ps2_data_oe;
    cyc(Half);
    bits[0] = ps2_data_line;
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      cyc(Half);
      if (i == stop_after) return;
      dev_clk_low = 1'b0;
      cyc(Half / 2);
      if (i <= 10) bits[i] = ps2_data_line;
      if (i == 10 && ack) dev_data_low = 1'b1;
      if (glitch && (i == 3 || i == 6)) begin
        cyc(5); dev_clk_low = 1'b1; cyc(3); dev_clk_low = 1'b0; cyc(Half / 2 - 8);
      end else begin
        cyc(Half / 2);
      end
    end
    cyc(Half / 2);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_result(input int d0, input int e0, input int limit, output int res);
    int t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < limit) begin cyc(1); t++; end
    cyc(2);
    if (done_cnt != d0) res = 0;
    else if (err_cnt != e0) res = last_nack ? 1 : 2;
    else res = 3;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      errors++; $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe});
    end
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL reset_ready_busy: got %b want 10", {tx_ready, busy});
    end
    checks++;
    if ({done, err, err_nack} !== 3'b000) begin
      errors++; $display("FAIL reset_status: got %b want 000", {done, err, err_nack});
    end
    cyc(3);
    rst = 1'b0;
    cyc(20);
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready: got %b want 1", tx_ready);
    end
  endtask

  task automatic test_frame(input logic [7:0] b, input bit glitch);
    logic [10:0] bits, exp;
    logic        so;
    int          inh, d0, e0, res, er;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(b, 0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL busy_%h: got %b want 1", b, busy); end
    dev_frame(1'b1, glitch, 0, bits, inh, so);
    exp = exp_q.pop_front();
    er  = exp_res_q.pop_front();
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL frame_%h: got %b want %b", b, bits, exp); end
    checks++;
    if (inh < Inh || inh > Inh + 2) begin
      errors++; $display("FAIL inhibit_%h: got %0d cycles want %0d..%0d", b, inh, Inh, Inh + 2);
    end
    checks++;
    if (so !== 1'b1) begin errors++; $display("FAIL rts_%h: got data_oe=%b want 1", b, so); end
    wait_result(d0, e0, 500, res);
    checks++;
    if (res != er) begin errors++; $display("FAIL result_%h: got %0d want %0d", b, res, er); end
    checks++;
    if (done_cnt - d0 != 1 || err_cnt != e0) begin
      errors++; $display("FAIL pulses_%h: got done=%0d err=%0d want 1 0", b, done_cnt - d0,
                         err_cnt - e0);
    end
    checks++;
    if ({tx_ready, busy} !== 2'b10) begin
      errors++; $display("FAIL after_%h: got %b want 10", b, {tx_ready, busy});
    end
  endtask

  task automatic test_nack();
    logic [10:0] bits, exp;
    logic        so;
    int          inh, d0, e0, res, er;
    d0 = done_cnt; e0 = err_cnt;
`ifdef PS2_TX_RETRY_EN
    send_byte(8'hF4, 0);
`else
    send_byte(8'hF4, 1);
`endif
    dev_frame(1'b0, 1'b0, 0, bits, inh, so);
    exp = exp_q.pop_front();
    er  = exp_res_q.pop_front();
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL nack_frame: got %b want %b", bits, exp); end
`ifdef PS2_TX_RETRY_EN
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL retry_busy: got %b want 1", busy); end
    dev_frame(1'b1, 1'b0, 0, bits, inh, so);
    checks++;
    if (bits !== exp) begin errors++; $display("FAIL retry_frame: got %b want %b", bits, exp); end
`endif
    wait_result(d0, e0, 500, res);
    checks++;
    if (res != er) begin errors++; $display("FAIL nack_result: got %0d want %0d", res, er); end
`ifndef PS2_TX_RETRY_EN
    checks++;
    if (err_oe !== 2'b00) begin errors++; $display("FAIL nack_oe: got %b want 00", err_oe); end
    checks++;
    if (done_cnt != d0) begin
      errors++; $display("FAIL nack_done: got %0d want 0", done_cnt - d0);
    end
`endif
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL nack_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_timeout();
    int d0, e0, res, er, rel, t, rounds;
    d0 = done_cnt; e0 = err_cnt; rel = 0;
    send_byte(8'hF4, 2);
    void'(exp_q.pop_front());
    er = exp_res_q.pop_front();
`ifdef PS2_TX_RETRY_EN
    rounds = 2;
`else
    rounds = 1;
`endif
    for (int r = 0; r < rounds; r++) begin
      t = 0;
      while (ps2_clk_oe !== 1'b1 && t < Tmo + Inh + 500) begin cyc(1); t++; end
      t = 0;
      while (ps2_clk_oe === 1'b1 && t < Inh + 100) begin cyc(1); t++; end
      rel = cyc_cnt;
    end
    wait_result(d0, e0, Tmo + 200, res);
    checks++;
    if (res != er) begin errors++; $display("FAIL tmo_result: got %0d want %0d", res, er); end
    checks++;
    if (err_cyc - rel != Tmo) begin
      errors++; $display("FAIL tmo_latency: got %0d want %0d", err_cyc - rel, Tmo);
    end
    checks++;
    if (err_oe !== 2'b00) begin errors++; $display("FAIL tmo_oe: got %b want 00", err_oe); end
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++; $display("FAIL tmo_pulses: got %0d want 1", err_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    logic        so;
    int          inh, d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4, 0);
    void'(exp_q.pop_front());
    void'(exp_res_q.pop_front());
    dev_frame(1'b1, 1'b0, 5, bits, inh, so);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      errors++; $display("FAIL mid_reset: got oe/ready %b want 001",
                         {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
    cyc(2);
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    rst = 1'b0;
    cyc(20);
    checks++;
    if (done_cnt != d0 || err_cnt != e0) begin
      errors++; $display("FAIL mid_pulses: got done=%0d err=%0d want 0 0", done_cnt - d0,
                         err_cnt - e0);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_frame(8'hF4, 1'b0);
    test_frame(8'hFF, 1'b0);
    test_frame(8'h00, 1'b0);
    test_nack();
    test_timeout();
    test_frame(8'hF4, 1'b1);
    test_reset_mid();
    test_frame(8'hF4, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
